// File: rtl/pll_sup_pkg.sv
// Shared types and default constants for the PLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        SUP_RESET_PLL = 3'd0,
        SUP_WAIT_LOCK = 3'd1,
        SUP_STABLE    = 3'd2,
        SUP_CHECK     = 3'd3,
        SUP_RUN       = 3'd4
    } sup_state_e;

    localparam int unsigned DefRstCycles    = 16;
    localparam int unsigned DefLockTimeout  = 125000;
    localparam int unsigned DefStableCycles = 1024;
    localparam int unsigned DefWinCycles    = 1000;
    localparam int unsigned DefExpEdges     = 384;
    localparam int unsigned DefTol          = 8;
    localparam int unsigned FaultW          = 8;
    localparam int unsigned StateW          = 3;

    function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// PLL-side and reset-tree signals of the supervisor, grouped as one bundle.
interface pll_lock_supervisor_if;
    import pll_sup_pkg::*;

    logic              pll_locked;
    logic              clk_tog;
    logic              pll_rst;
    logic              sys_rst_n;
    logic              ready;
    logic [FaultW-1:0] fault_cnt;
    logic [StateW-1:0] state;

    modport master (
        input  pll_locked, clk_tog,
        output pll_rst, sys_rst_n, ready, fault_cnt, state
    );

    modport slave (
        output pll_locked, clk_tog,
        input  pll_rst, sys_rst_n, ready, fault_cnt, state
    );

endinterface

// File: rtl/sync2.sv
// Generic two-flop synchronizer with a configurable reset value.
module sync2 #(
    parameter logic RstVal = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= {2{RstVal}};
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Brings up the system PLL, verifies lock and output frequency, and gates the system reset.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = DefRstCycles,
    parameter int unsigned LOCK_TIMEOUT  = DefLockTimeout,
    parameter int unsigned STABLE_CYCLES = DefStableCycles,
    parameter int unsigned WIN_CYCLES    = DefWinCycles,
    parameter int unsigned EXP_EDGES     = DefExpEdges,
    parameter int unsigned TOL           = DefTol
) (
    input  logic                  refclk_i,
    input  logic                  rst_ni,
    pll_lock_supervisor_if.master sup_io
);

    localparam int unsigned CntW  = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) + 1);
    localparam int unsigned WinW  = $clog2(WIN_CYCLES + 1);
    localparam int unsigned EdgeW = $clog2(2 * EXP_EDGES + 1);

    localparam logic [CntW-1:0]  RstLast     = CntW'(RST_CYCLES - 1);
    localparam logic [CntW-1:0]  TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
    localparam logic [CntW-1:0]  StableLast  = CntW'(STABLE_CYCLES - 1);
    localparam logic [WinW-1:0]  WinLast     = WinW'(WIN_CYCLES - 1);
    localparam logic [EdgeW-1:0] ExpE        = EdgeW'(EXP_EDGES);
    localparam logic [EdgeW-1:0] TolE        = EdgeW'(TOL);
    localparam logic [EdgeW-1:0] EdgeMax     = '1;

    sup_state_e        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WinW-1:0]   win_q, win_d;
    logic [EdgeW-1:0]  edge_q, edge_d;
    logic [FaultW-1:0] fault_q, fault_d;
    logic              pll_rst_q, run_q;
    logic              locked_s, tog_s, tog_q, tog_edge;
    logic              fault_inc, win_end, win_pass;
    logic [EdgeW-1:0]  edge_sum, edge_diff;

    sync2 #(.RstVal(1'b0)) u_sync_lock (
        .clk_i (refclk_i),
        .rst_ni(rst_ni),
        .d_i   (sup_io.pll_locked),
        .q_o   (locked_s)
    );

    sync2 #(.RstVal(1'b0)) u_sync_tog (
        .clk_i (refclk_i),
        .rst_ni(rst_ni),
        .d_i   (sup_io.clk_tog),
        .q_o   (tog_s)
    );

    assign tog_edge  = tog_s ^ tog_q;
    // Count including this cycle's edge so the last-cycle check sees the whole window.
    assign edge_sum  = (edge_q == EdgeMax) ? edge_q : edge_q + {{(EdgeW-1){1'b0}}, tog_edge};
    assign edge_diff = (edge_sum >= ExpE) ? edge_sum - ExpE : ExpE - edge_sum;
    assign win_pass  = (edge_diff <= TolE);
    assign win_end   = (win_q == WinLast);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        win_d     = win_q + 1'b1;
        edge_d    = edge_sum;
        fault_inc = 1'b0;
        unique case (state_q)
            SUP_RESET_PLL: begin
                if (cnt_q == RstLast) begin
                    state_d = SUP_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            SUP_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = SUP_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TimeoutLast) begin
                    state_d   = SUP_RESET_PLL;
                    cnt_d     = '0;
                    fault_inc = 1'b1;
                end
            end
            SUP_STABLE: begin
                if (!locked_s) begin
                    state_d = SUP_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == StableLast) begin
                    state_d = SUP_CHECK;
                    cnt_d   = '0;
                    win_d   = '0;
                    edge_d  = '0;
                end
            end
            SUP_CHECK: begin
                if (win_end) begin
                    win_d  = '0;
                    edge_d = '0;
                    if (win_pass) begin
                        state_d = SUP_RUN;
                    end else begin
                        state_d   = SUP_RESET_PLL;
                        cnt_d     = '0;
                        fault_inc = 1'b1;
                    end
                end
            end
            SUP_RUN: begin
                if (win_end) begin
                    win_d  = '0;
                    edge_d = '0;
                end
                // Lock loss and a failed window on one cycle collapse into a single fault.
                if (!locked_s || (win_end && !win_pass)) begin
                    state_d   = SUP_RESET_PLL;
                    cnt_d     = '0;
                    fault_inc = 1'b1;
                end
            end
            default: begin
                state_d = SUP_RESET_PLL;
                cnt_d   = '0;
            end
        endcase
        fault_d = (fault_inc && (fault_q != '1)) ? fault_q + 1'b1 : fault_q;
    end

    always_ff @(posedge refclk_i) begin
        if (!rst_ni) begin
            state_q   <= SUP_RESET_PLL;
            cnt_q     <= '0;
            win_q     <= '0;
            edge_q    <= '0;
            fault_q   <= '0;
            tog_q     <= 1'b0;
            pll_rst_q <= 1'b1;
            run_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            win_q     <= win_d;
            edge_q    <= edge_d;
            fault_q   <= fault_d;
            tog_q     <= tog_s;
            pll_rst_q <= (state_d == SUP_RESET_PLL);
            run_q     <= (state_d == SUP_RUN);
        end
    end

    assign sup_io.pll_rst   = pll_rst_q;
    assign sup_io.sys_rst_n = run_q;
    assign sup_io.ready     = run_q;
    assign sup_io.fault_cnt = fault_q;
    assign sup_io.state     = state_q;

endmodule
